alu_issue_queue: RTL and testbench

Reservation station and scheduler in front of the single integer ALU. Holds up to DEPTH dispatched ALU micro-ops and tracks source-operand readiness from writeback tag broadcasts. Each cycle it selects one ready op for the ALU read/execute stage over a valid/ready handshake. Sits between rename/dispatch and the ALU; flushed on pipeline redirect.

---
 rtl/alu_issue_queue_pkg.sv | 31 +++
 rtl/alu_iq_select.sv | 31 +++
 rtl/alu_issue_queue.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
// rtl/alu_issue_queue_pkg.sv - shared entry type, ALU op indices and default widths
package alu_issue_queue_pkg;

  localparam int TYPE_W = 10;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 6;

  // One-hot bit positions within alu_type
  localparam int ALU_ADD  = 0;
  localparam int ALU_SLT  = 1;
  localparam int ALU_SLTU = 2;
  localparam int ALU_XOR  = 3;
  localparam int ALU_OR   = 4;
  localparam int ALU_AND  = 5;
  localparam int ALU_SLL  = 6;
  localparam int ALU_SRL  = 7;
  localparam int ALU_SRA  = 8;
  localparam int ALU_SUB  = 9;

  typedef struct packed {
    logic              valid;
    logic [TYPE_W-1:0] alu_type;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic              rdy1;
    logic              rdy2;
    logic [PREG_W-1:0] prd;
    logic [ROB_W-1:0]  robidx;
  } iq_entry_t;

endpackage

// File: rtl/alu_iq_select.sv
// rtl/alu_iq_select.sv - one-hot grant of a ready entry; oldest-first when ALU_IQ_AGE_SELECT_EN
module alu_iq_select
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            ready,
`ifdef ALU_IQ_AGE_SELECT_EN
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
`endif
  output logic [DEPTH-1:0]            grant
);

  always_comb begin
    grant = '0;
`ifdef ALU_IQ_AGE_SELECT_EN
    // older[i][j] set means entry j was enqueued before entry i
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i] & !(|(ready & older[i]));
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - ALU reservation station with tag wakeup and single-issue select
// ALU_IQ_AGE_SELECT_EN: oldest-first select via age matrix; undefined: lowest index wins
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PREG_W = alu_issue_queue_pkg::PREG_W,
  parameter int ROB_W  = alu_issue_queue_pkg::ROB_W,
  parameter int TYPE_W = alu_issue_queue_pkg::TYPE_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [TYPE_W-1:0]          enq_alu_type,
  input  logic [PREG_W-1:0]          enq_prs1,
  input  logic [PREG_W-1:0]          enq_prs2,
  input  logic                       enq_src1_rdy,
  input  logic                       enq_src2_rdy,
  input  logic [PREG_W-1:0]          enq_prd,
  input  logic [ROB_W-1:0]           enq_robidx,
  input  logic                       wb_valid,
  input  logic [PREG_W-1:0]          wb_prd,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [TYPE_W-1:0]          issue_alu_type,
  output logic [PREG_W-1:0]          issue_prs1,
  output logic [PREG_W-1:0]          issue_prs2,
  output logic [PREG_W-1:0]          issue_prd,
  output logic [ROB_W-1:0]           issue_robidx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [TYPE_W-1:0] type_q [DEPTH];
  logic [TYPE_W-1:0] type_d [DEPTH];
  logic [PREG_W-1:0] prs1_q [DEPTH];
  logic [PREG_W-1:0] prs1_d [DEPTH];
  logic [PREG_W-1:0] prs2_q [DEPTH];
  logic [PREG_W-1:0] prs2_d [DEPTH];
  logic [PREG_W-1:0] prd_q  [DEPTH];
  logic [PREG_W-1:0] prd_d  [DEPTH];
  logic [ROB_W-1:0]  rob_q  [DEPTH];
  logic [ROB_W-1:0]  rob_d  [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  ready_vec, grant;
  logic [IDX_W-1:0]  free_idx;
  logic              enq_fire, issue_fire;

  assign enq_ready   = (count_q < CNT_W'(DEPTH));
  assign count       = count_q;
  assign ready_vec   = valid_q & rdy1_q & rdy2_q;
  assign issue_valid = (|ready_vec) & !flush;
  assign enq_fire    = enq_valid & enq_ready & !flush;
  assign issue_fire  = issue_valid & issue_ready;

`ifdef ALU_IQ_AGE_SELECT_EN
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  // New entry is youngest: clear its column so stale bits from a previous occupant vanish
  always_comb begin
    older_d = older_q;
    if (enq_fire) begin
      for (int k = 0; k < DEPTH; k++) older_d[k][free_idx] = 1'b0;
      older_d[free_idx] = valid_q;
      older_d[free_idx][free_idx] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) older_q <= '0;
    else          older_q <= older_d;
  end

  alu_iq_select #(.DEPTH(DEPTH)) u_select (.ready(ready_vec), .older(older_q), .grant(grant));
`else
  alu_iq_select #(.DEPTH(DEPTH)) u_select (.ready(ready_vec), .grant(grant));
`endif

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    type_d  = type_q;
    prs1_d  = prs1_q;
    prs2_d  = prs2_q;
    prd_d   = prd_q;
    rob_d   = rob_q;
    if (wb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && prs1_q[i] == wb_prd) rdy1_d[i] = 1'b1;
        if (valid_q[i] && prs2_q[i] == wb_prd) rdy2_d[i] = 1'b1;
      end
    end
    if (issue_fire) valid_d = valid_d & ~grant;
    // Same-cycle broadcast is folded in so a dispatch racing its producer is not lost
    if (enq_fire) begin
      valid_d[free_idx] = 1'b1;
      type_d[free_idx]  = enq_alu_type;
      prs1_d[free_idx]  = enq_prs1;
      prs2_d[free_idx]  = enq_prs2;
      prd_d[free_idx]   = enq_prd;
      rob_d[free_idx]   = enq_robidx;
      rdy1_d[free_idx]  = enq_src1_rdy | (enq_prs1 == '0) | (wb_valid & (enq_prs1 == wb_prd));
      rdy2_d[free_idx]  = enq_src2_rdy | (enq_prs2 == '0) | (wb_valid & (enq_prs2 == wb_prd));
    end
    if (flush) valid_d = '0;
  end

  always_comb begin
    count_d = count_q;
    if (flush)                         count_d = '0;
    else if (enq_fire && !issue_fire)  count_d = count_q + 1'b1;
    else if (!enq_fire && issue_fire)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= '0;
        prs1_q[i] <= '0;
        prs2_q[i] <= '0;
        prd_q[i]  <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count_q <= count_d;
      type_q  <= type_d;
      prs1_q  <= prs1_d;
      prs2_q  <= prs2_d;
      prd_q   <= prd_d;
      rob_q   <= rob_d;
    end
  end

  always_comb begin
    issue_alu_type = '0;
    issue_prs1     = '0;
    issue_prs2     = '0;
    issue_prd      = '0;
    issue_robidx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_valid && grant[i]) begin
        issue_alu_type = issue_alu_type | type_q[i];
        issue_prs1     = issue_prs1 | prs1_q[i];
        issue_prs2     = issue_prs2 | prs2_q[i];
        issue_prd      = issue_prd | prd_q[i];
        issue_robidx   = issue_robidx | rob_q[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue (honours ALU_IQ_AGE_SELECT_EN)
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n, flush, enq_valid, enq_ready;
  logic [TYPE_W-1:0] enq_alu_type, issue_alu_type;
  logic [PREG_W-1:0] enq_prs1, enq_prs2, enq_prd, wb_prd;
  logic [PREG_W-1:0] issue_prs1, issue_prs2, issue_prd;
  logic              enq_src1_rdy, enq_src2_rdy, wb_valid, issue_valid, issue_ready;
  logic [ROB_W-1:0]  enq_robidx, issue_robidx;
  logic [3:0]        count;

  int checks   = 0;
  int failures = 0;
  iq_entry_t exp_q[$];

  always #5 clock = ~clock;

  alu_issue_queue dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_alu_type(enq_alu_type),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2), .enq_src1_rdy(enq_src1_rdy),
    .enq_src2_rdy(enq_src2_rdy), .enq_prd(enq_prd), .enq_robidx(enq_robidx),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_type(issue_alu_type), .issue_prs1(issue_prs1), .issue_prs2(issue_prs2),
    .issue_prd(issue_prd), .issue_robidx(issue_robidx), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0;
    wb_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drive_enq(input int op, input int p1, input logic r1, input int p2,
                           input logic r2, input int pd, input int rob);
    enq_valid    = 1'b1;
    enq_alu_type = TYPE_W'(1) << op;
    enq_prs1     = PREG_W'(p1);
    enq_src1_rdy = r1;
    enq_prs2     = PREG_W'(p2);
    enq_src2_rdy = r2;
    enq_prd      = PREG_W'(pd);
    enq_robidx   = ROB_W'(rob);
  endtask

  task automatic expect_issue(input int op, input int p1, input int p2, input int pd, input int rob);
    iq_entry_t e;
    e          = '0;
    e.alu_type = TYPE_W'(1) << op;
    e.prs1     = PREG_W'(p1);
    e.prs2     = PREG_W'(p2);
    e.prd      = PREG_W'(pd);
    e.robidx   = ROB_W'(rob);
    exp_q.push_back(e);
  endtask

  task automatic wake(input int tag);
    wb_valid = 1'b1;
    wb_prd   = PREG_W'(tag);
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard
  always @(negedge clock) begin
    if (reset_n && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_prd", 32'(issue_prd), 32'hFFFF);
      end else begin
        iq_entry_t e;
        e = exp_q.pop_front();
        chk("issue_prd",    32'(issue_prd),      32'(e.prd));
        chk("issue_robidx", 32'(issue_robidx),   32'(e.robidx));
        chk("issue_type",   32'(issue_alu_type), 32'(e.alu_type));
        chk("issue_prs1",   32'(issue_prs1),     32'(e.prs1));
        chk("issue_prs2",   32'(issue_prs2),     32'(e.prs2));
      end
    end
  end

  initial begin
    reset_n = 1'b0; issue_ready = 1'b1; wb_prd = '0;
    enq_alu_type = '0; enq_prs1 = '0; enq_prs2 = '0; enq_prd = '0; enq_robidx = '0;
    enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_enq_ready",   32'(enq_ready),      32'd1);
    chk("rst_issue_valid", 32'(issue_valid),    32'd0);
    chk("rst_count",       32'(count),          32'd0);
    chk("rst_issue_prd",   32'(issue_prd),      32'd0);
    chk("rst_issue_type",  32'(issue_alu_type), 32'd0);

    // Ready-at-dispatch op: visible one cycle after enqueue
    step();
    drive_enq(ALU_ADD, 5, 1'b1, 0, 1'b0, 9, 1);
    expect_issue(ALU_ADD, 5, 0, 9, 1);
    @(negedge clock); chk("enq_no_bypass", 32'(issue_valid), 32'd0);
    step(); idle();
    @(negedge clock); chk("issue_next_cycle", 32'(issue_valid), 32'd1);
    chk("count_one", 32'(count), 32'd1);
    step();
    @(negedge clock); chk("count_drained", 32'(count), 32'd0);

    // Wakeup after dispatch: issuable the cycle after broadcast, not during it
    step();
    drive_enq(ALU_SUB, 7, 1'b0, 3, 1'b1, 12, 2);
    step(); idle();
    @(negedge clock); chk("wait_src", 32'(issue_valid), 32'd0);
    step(); wake(7);
    expect_issue(ALU_SUB, 7, 3, 12, 2);
    @(negedge clock); chk("wb_no_bypass", 32'(issue_valid), 32'd0);
    step(); idle();
    @(negedge clock); chk("wb_wake", 32'(issue_valid), 32'd1);
    step();

    // Broadcast in the dispatch cycle must not be lost
    drive_enq(ALU_XOR, 7, 1'b0, 0, 1'b0, 13, 3);
    wake(7);
    expect_issue(ALU_XOR, 7, 0, 13, 3);
    @(negedge clock); chk("enq_wb_same_no_bypass", 32'(issue_valid), 32'd0);
    step(); idle();
    @(negedge clock); chk("enq_wb_same_wake", 32'(issue_valid), 32'd1);
    step();

    // Fill all eight slots with waiting ops
    for (int i = 0; i < 8; i++) begin
      drive_enq(ALU_OR, 20 + i, 1'b0, 0, 1'b1, 30 + i, 10 + i);
      step();
    end
    idle();
    @(negedge clock);
    chk("full_count", 32'(count), 32'd8);
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    step();
    drive_enq(ALU_AND, 0, 1'b1, 0, 1'b1, 50, 40);
    wake(20);
    expect_issue(ALU_OR, 20, 0, 30, 10);
    step(); wb_valid = 1'b0;
    @(negedge clock);
    chk("full_issue_valid", 32'(issue_valid), 32'd1);
    chk("full_same_cycle_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_held_count", 32'(count), 32'd8);
    step();
    expect_issue(ALU_AND, 0, 0, 50, 40);
    @(negedge clock);
    chk("freed_enq_ready", 32'(enq_ready), 32'd1);
    chk("freed_count", 32'(count), 32'd7);
    step(); idle();
    @(negedge clock); chk("refill_count", 32'(count), 32'd8);
    step();
    @(negedge clock); chk("after_x_count", 32'(count), 32'd7);

    // Flush with a ready entry present and a competing dispatch
    step(); wake(21);
    expect_issue(ALU_OR, 21, 0, 31, 11);
    step(); idle();
    step(); wake(22);
    step(); idle();
    flush = 1'b1;
    drive_enq(ALU_AND, 0, 1'b1, 0, 1'b1, 51, 41);
    @(negedge clock);
    chk("flush_issue_valid", 32'(issue_valid), 32'd0);
    chk("flush_pre_count", 32'(count), 32'd6);
    step(); idle();
    @(negedge clock);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_after_valid", 32'(issue_valid), 32'd0);
    for (int t = 23; t < 28; t++) begin
      step(); wake(t);
    end
    step(); idle();
    step();
    @(negedge clock); chk("flush_dropped", 32'(issue_valid), 32'd0);

    // Ordering: A lands in slot 3, later B lands in slot 0; both wake together
    step();
    for (int i = 0; i < 3; i++) begin
      drive_enq(ALU_OR, 40 + i, 1'b0, 0, 1'b1, 60 + i, 20 + i);
      step();
    end
    drive_enq(ALU_SLL, 44, 1'b0, 0, 1'b1, 63, 23);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      wake(40 + i);
      expect_issue(ALU_OR, 40 + i, 0, 60 + i, 20 + i);
      step();
    end
    idle();
    repeat (2) step();
    @(negedge clock); chk("age_setup_count", 32'(count), 32'd1);
    step();
    drive_enq(ALU_SRA, 44, 1'b0, 0, 1'b1, 64, 24);
    step(); idle();
    wake(44);
`ifdef ALU_IQ_AGE_SELECT_EN
    expect_issue(ALU_SLL, 44, 0, 63, 23);
    expect_issue(ALU_SRA, 44, 0, 64, 24);
`else
    expect_issue(ALU_SRA, 44, 0, 64, 24);
    expect_issue(ALU_SLL, 44, 0, 63, 23);
`endif
    step(); idle();
    repeat (3) step();
    @(negedge clock); chk("age_drained", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle discards a waiting op
    step();
    drive_enq(ALU_SRL, 45, 1'b0, 0, 1'b1, 65, 25);
    step(); idle();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_enq_ready", 32'(enq_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    drive_enq(ALU_SLT, 0, 1'b1, 0, 1'b1, 66, 26);
    expect_issue(ALU_SLT, 0, 0, 66, 26);
    step(); idle();
    @(negedge clock);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_issue", 32'(issue_valid), 32'd1);
    step(); wake(45);
    step(); idle();
    repeat (3) step();
    @(negedge clock);
    chk("post_rst_old_gone", 32'(issue_valid), 32'd0);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
